guess_entry: RTL

Composes the player's four-slot colour guess and commits it to the turn history over a valid/ready handshake. Sits between the debounced button front end and `history`. It drives the `guess0`..`guess3` buses and hands each committed guess to `history` for storage. It also tracks the turn count and locks the board once the final turn is committed.

---
 rtl/guess_entry.sv | 118 +++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// Four-slot colour guess editor with valid/ready commit to history and turn tracking.
// Optional duplicate-colour refusal on select: define GUESS_ENTRY_DUP_CHECK_EN.
module guess_entry #(
    parameter int unsigned NUM_COLORS = 6,
    parameter int unsigned MAX_TURNS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_select,
    input  logic       commit_ready,
    output logic [2:0] guess0,
    output logic [2:0] guess1,
    output logic [2:0] guess2,
    output logic [2:0] guess3,
    output logic [1:0] cursor,
    output logic       commit_valid,
    output logic [2:0] turn,
    output logic       last_turn,
    output logic       reject
);

    localparam logic [1:0] S_EDIT   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] COLOR_MAX = 3'(NUM_COLORS - 1);
    localparam logic [2:0] TURN_LAST = 3'(MAX_TURNS - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0][2:0]  slots_q, slots_d;
    logic [1:0]       cursor_q, cursor_d;
    logic [2:0]       turn_q, turn_d;
    logic             reject_d;
    logic             dup;

`ifdef GUESS_ENTRY_DUP_CHECK_EN
    assign dup = (slots_q[0] == slots_q[1]) | (slots_q[0] == slots_q[2]) |
                 (slots_q[0] == slots_q[3]) | (slots_q[1] == slots_q[2]) |
                 (slots_q[1] == slots_q[3]) | (slots_q[2] == slots_q[3]);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        slots_d  = slots_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        reject_d = 1'b0;
        case (state_q)
            S_EDIT: begin
                if (!mode) begin
                    if (btn_select) begin
                        if (dup) reject_d = 1'b1;
                        else     state_d  = S_COMMIT;
                    end else begin
                        // Colour edit targets the pre-move cursor position.
                        if (btn_up && !btn_down)
                            slots_d[cursor_q] = (slots_q[cursor_q] == COLOR_MAX) ? 3'd0
                                                : slots_q[cursor_q] + 3'd1;
                        else if (btn_down && !btn_up)
                            slots_d[cursor_q] = (slots_q[cursor_q] == 3'd0) ? COLOR_MAX
                                                : slots_q[cursor_q] - 3'd1;
                        if (btn_right && !btn_left)
                            cursor_d = cursor_q + 2'd1;
                        else if (btn_left && !btn_right)
                            cursor_d = cursor_q - 2'd1;
                    end
                end
            end
            S_COMMIT: begin
                if (commit_ready) begin
                    slots_d  = '0;
                    cursor_d = '0;
                    if (turn_q == TURN_LAST) state_d = S_DONE;
                    else begin
                        state_d = S_EDIT;
                        turn_d  = turn_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_EDIT;
            slots_q      <= '0;
            cursor_q     <= '0;
            turn_q       <= '0;
            commit_valid <= 1'b0;
            last_turn    <= 1'b0;
            reject       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slots_q      <= slots_d;
            cursor_q     <= cursor_d;
            turn_q       <= turn_d;
            commit_valid <= (state_d == S_COMMIT);
            last_turn    <= (state_d == S_DONE);
            reject       <= reject_d;
        end
    end

    assign guess0 = slots_q[0];
    assign guess1 = slots_q[1];
    assign guess2 = slots_q[2];
    assign guess3 = slots_q[3];
    assign cursor = cursor_q;
    assign turn   = turn_q;

endmodule
